// File: rtl/hack_rom_loader_pkg.sv
// hack_rom_loader_pkg: default ROM widths and loader FSM state encoding
package hack_rom_loader_pkg;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 15;
    typedef enum logic [1:0] {IDLE, WAIT_SCK, WRITE, ACK_HOLD} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer
// Ports: clk, reset (async, active-high), d (async input), q (synchronized output)
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge reset)
        if (reset) {q, meta} <= 2'b00;
        else       {q, meta} <= {meta, d};
endmodule

// File: rtl/rom_loader.sv
// rom_loader: loads ROM words from an asynchronous load/sck/ack handshake
// Ports: clk, reset (async, active-high); rom_loader_load/_data/_sck in, rom_loader_ack out;
//        rom_write_enable/rom_address/rom_write_data drive the ROM write port;
//        loading (session active), word_count (words written), overflow (sticky, ROM full)
module rom_loader
    import hack_rom_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rom_loader_load,
    input  logic [DATA_WIDTH-1:0] rom_loader_data,
    input  logic                  rom_loader_sck,
    output logic                  rom_loader_ack,
    output logic                  rom_write_enable,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic [DATA_WIDTH-1:0] rom_write_data,
    output logic                  loading,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow
);
    logic load_s, sck_s, load_q, sck_q, load_rise, sck_rise, full;
    state_t state, next_state;

    sync_2ff u_load_sync (.clk(clk), .reset(reset), .d(rom_loader_load), .q(load_s));
    sync_2ff u_sck_sync  (.clk(clk), .reset(reset), .d(rom_loader_sck),  .q(sck_s));

    // Edge pulses are registered, so a rising sck acts two cycles after it is synchronized.
    always_ff @(posedge clk or posedge reset)
        if (reset) {load_q, sck_q, load_rise, sck_rise} <= 4'b0000;
        else       {load_q, sck_q, load_rise, sck_rise} <= {load_s, sck_s, load_s & ~load_q, sck_s & ~sck_q};

    assign full             = word_count[ADDR_WIDTH];
    assign loading          = state != IDLE;
    assign rom_write_enable = state == WRITE && !full;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     next_state = load_rise ? WAIT_SCK : IDLE;
            WAIT_SCK: next_state = !load_s ? IDLE : sck_rise ? WRITE : WAIT_SCK;
            WRITE:    next_state = load_s ? ACK_HOLD : IDLE;
            ACK_HOLD: next_state = !load_s ? IDLE : !sck_s ? WAIT_SCK : ACK_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state          <= IDLE;
            rom_loader_ack <= 1'b0;
            rom_address    <= '0;
            rom_write_data <= '0;
            word_count     <= '0;
            overflow       <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && load_rise) begin
                rom_address <= '0;
                word_count  <= '0;
                overflow    <= 1'b0;
            end
            if (state == WAIT_SCK && load_s && sck_rise) rom_write_data <= rom_loader_data;
            if (state == WRITE) begin
                rom_loader_ack <= load_s;
                if (full) overflow <= 1'b1;
                else begin
                    word_count <= word_count + 1'b1;
                    // the last address is held rather than wrapping to 0
                    if (!(&rom_address)) rom_address <= rom_address + 1'b1;
                end
            end
            if (state == ACK_HOLD && (!load_s || !sck_s)) rom_loader_ack <= 1'b0;
        end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized self-checking bench for rom_loader (default and 4-word ROM)
module tb_rom_loader;
    logic        clk = 0, reset = 0, load = 0, sck = 0;
    logic [15:0] data = 0;
    logic        ack_a, we_a, loading_a, ovf_a;
    logic [14:0] addr_a;
    logic [15:0] wd_a, cnt_a;
    logic        ack_b, we_b, loading_b, ovf_b;
    logic [1:0]  addr_b;
    logic [15:0] wd_b;
    logic [2:0]  cnt_b;
    int checks = 0, passes = 0, we_cnt = 0;
    logic [15:0] words[$];
    logic [14:0] oa_addr[$];
    logic [15:0] oa_data[$];
    logic [1:0]  ob_addr[$];
    logic [15:0] ob_data[$];

    always #5 clk = ~clk;

    rom_loader dut_a (
        .clk(clk), .reset(reset), .rom_loader_load(load), .rom_loader_data(data),
        .rom_loader_sck(sck), .rom_loader_ack(ack_a), .rom_write_enable(we_a),
        .rom_address(addr_a), .rom_write_data(wd_a), .loading(loading_a),
        .word_count(cnt_a), .overflow(ovf_a));

    rom_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .rom_loader_load(load), .rom_loader_data(data),
        .rom_loader_sck(sck), .rom_loader_ack(ack_b), .rom_write_enable(we_b),
        .rom_address(addr_b), .rom_write_data(wd_b), .loading(loading_b),
        .word_count(cnt_b), .overflow(ovf_b));

    always @(negedge clk) begin
        if (we_a) begin oa_addr.push_back(addr_a); oa_data.push_back(wd_a); we_cnt++; end
        if (we_b) begin ob_addr.push_back(addr_b); ob_data.push_back(wd_b); end
    end

    task automatic clear_obs();
        oa_addr.delete(); oa_data.delete(); ob_addr.delete(); ob_data.delete();
    endtask

    task automatic start_session();
        clear_obs();
        load = 1;
        repeat (6) @(negedge clk);
    endtask

    task automatic end_session();
        load = 0;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] d);
        data = d;
        #($urandom_range(1, 9));
        sck = 1;
        for (int i = 0; i < 20 && !ack_a; i++) @(negedge clk);
        checks++;
        if (ack_a !== 1'b1) $display("FAIL ack_rise got %b want 1", ack_a); else passes++;
        #($urandom_range(1, 9));
        sck = 0;
        for (int i = 0; i < 20 && ack_a; i++) @(negedge clk);
        checks++;
        if (ack_a !== 1'b0) $display("FAIL ack_fall got %b want 0", ack_a); else passes++;
        #($urandom_range(1, 9));
    endtask

    task automatic test_reset();
        #1 reset = 1;
        #1;
        checks++;
        if ({ack_a, we_a, loading_a, ovf_a, addr_a, wd_a, cnt_a} !== '0)
            $display("FAIL reset_outputs got %0h want 0", {ack_a, we_a, loading_a, ovf_a, addr_a, wd_a, cnt_a});
        else passes++;
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        words = {16'hEA87, 16'hFFFF, 16'h0000};
        start_session();
        checks++;
        if (loading_a !== 1'b1 || cnt_a !== 16'd0) $display("FAIL start loading=%b count=%0d want 1/0", loading_a, cnt_a); else passes++;
        foreach (words[i]) send_word(words[i]);
        checks++;
        if (loading_a !== 1'b1) $display("FAIL loading_hold got %b want 1", loading_a); else passes++;
        end_session();
        checks++;
        if (loading_a !== 1'b0) $display("FAIL loading_fall got %b want 0", loading_a); else passes++;
        checks++;
        if (cnt_a !== 16'd3 || addr_a !== 15'd3) $display("FAIL basic_count count=%0d addr=%0d want 3/3", cnt_a, addr_a); else passes++;
        checks++;
        if (oa_addr.size() != 3) $display("FAIL basic_nwrites got %0d want 3", oa_addr.size()); else passes++;
        for (int i = 0; i < 3 && i < oa_addr.size(); i++) begin
            checks++;
            if (oa_addr[i] !== 15'(i) || oa_data[i] !== words[i])
                $display("FAIL basic_write%0d got %0h:%0h want %0h:%0h", i, oa_addr[i], oa_data[i], i, words[i]);
            else passes++;
        end
    endtask

    task automatic test_no_load();
        logic ack_any = 0;
        we_cnt = 0;
        @(negedge clk) sck = 1;
        repeat (8) @(negedge clk) ack_any |= ack_a;
        sck = 0;
        repeat (4) @(negedge clk);
        checks++;
        if (we_cnt != 0 || ack_any !== 1'b0) $display("FAIL no_load writes=%0d ack=%b want 0/0", we_cnt, ack_any); else passes++;
    endtask

    task automatic test_latency();
        logic [6:0] we_pat, ack_pat;
        logic [3:0] fall_pat;
        start_session();
        data = 16'($urandom);
        @(negedge clk) sck = 1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            we_pat[i]  = we_a;
            ack_pat[i] = ack_a;
        end
        sck = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            fall_pat[i] = ack_a;
        end
        checks++;
        if (we_pat !== 7'b0001000) $display("FAIL lat_we got %b want 0001000", we_pat); else passes++;
        checks++;
        if (ack_pat !== 7'b1110000) $display("FAIL lat_ack got %b want 1110000", ack_pat); else passes++;
        checks++;
        if (fall_pat !== 4'b0011) $display("FAIL lat_ack_fall got %b want 0011", fall_pat); else passes++;
        checks++;
        if (oa_data.size() != 1 || oa_data[0] !== data) $display("FAIL lat_data got %0h want %0h", oa_data[0], data); else passes++;
        end_session();
    endtask

    task automatic test_overflow();
        words.delete();
        for (int i = 0; i < 5; i++) words.push_back(16'($urandom));
        start_session();
        foreach (words[i]) send_word(words[i]);
        end_session();
        checks++;
        if (ob_addr.size() != 4) $display("FAIL ovf_nwrites got %0d want 4", ob_addr.size()); else passes++;
        for (int i = 0; i < 4 && i < ob_addr.size(); i++) begin
            checks++;
            if (ob_addr[i] !== 2'(i) || ob_data[i] !== words[i])
                $display("FAIL ovf_write%0d got %0h:%0h want %0h:%0h", i, ob_addr[i], ob_data[i], i, words[i]);
            else passes++;
        end
        checks++;
        if (cnt_b !== 3'd4 || ovf_b !== 1'b1) $display("FAIL ovf_state count=%0d ovf=%b want 4/1", cnt_b, ovf_b); else passes++;
        checks++;
        if (cnt_a !== 16'd5 || ovf_a !== 1'b0) $display("FAIL big_state count=%0d ovf=%b want 5/0", cnt_a, ovf_a); else passes++;
    endtask

    task automatic test_random();
        for (int s = 0; s < 4; s++) begin
            int n = (s == 0) ? 2 : $urandom_range(1, 6);
            int cap;
            cap = n < 4 ? n : 4;
            words.delete();
            for (int i = 0; i < n; i++) words.push_back(16'($urandom));
            start_session();
            checks++;
            if (cnt_b !== 3'd0 || ovf_b !== 1'b0) $display("FAIL rnd_restart count=%0d ovf=%b want 0/0", cnt_b, ovf_b); else passes++;
            foreach (words[i]) send_word(words[i]);
            end_session();
            checks++;
            if (oa_addr.size() != n || ob_addr.size() != cap)
                $display("FAIL rnd_nwrites got %0d/%0d want %0d/%0d", oa_addr.size(), ob_addr.size(), n, cap);
            else passes++;
            for (int i = 0; i < n && i < oa_addr.size(); i++) begin
                checks++;
                if (oa_addr[i] !== 15'(i) || oa_data[i] !== words[i])
                    $display("FAIL rnd_write%0d got %0h:%0h want %0h:%0h", i, oa_addr[i], oa_data[i], i, words[i]);
                else passes++;
            end
            checks++;
            if (cnt_a !== 16'(n) || cnt_b !== 3'(cap) || ovf_b !== (n > 4))
                $display("FAIL rnd_state got %0d/%0d/%b want %0d/%0d/%b", cnt_a, cnt_b, ovf_b, n, cap, n > 4);
            else passes++;
        end
    endtask

    task automatic test_reset_in_write();
        logic [15:0] d;
        start_session();
        data = 16'h1234;
        sck = 1;
        for (int i = 0; i < 20 && !we_a; i++) @(negedge clk);
        #1 reset = 1;
        #1;
        checks++;
        if (we_a !== 1'b0 || loading_a !== 1'b0 || cnt_a !== 16'd0)
            $display("FAIL reset_write we=%b loading=%b count=%0d want 0/0/0", we_a, loading_a, cnt_a);
        else passes++;
        sck = 0;
        load = 0;
        @(negedge clk) reset = 0;
        repeat (2) @(negedge clk);
        d = 16'($urandom);
        start_session();
        send_word(d);
        end_session();
        checks++;
        if (oa_addr.size() != 1 || oa_addr[0] !== 15'd0 || oa_data[0] !== d || cnt_a !== 16'd1)
            $display("FAIL reset_restart got n=%0d %0h:%0h want 1 0:%0h", oa_addr.size(), oa_addr[0], oa_data[0], d);
        else passes++;
    endtask

    task automatic test_drop_in_ack();
        start_session();
        send_word(16'($urandom));
        data = 16'($urandom);
        sck = 1;
        for (int i = 0; i < 20 && !ack_a; i++) @(negedge clk);
        load = 0;
        repeat (5) @(negedge clk);
        checks++;
        if (ack_a !== 1'b0 || loading_a !== 1'b0 || cnt_a !== 16'd2)
            $display("FAIL drop_ack ack=%b loading=%b count=%0d want 0/0/2", ack_a, loading_a, cnt_a);
        else passes++;
        sck = 0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_load();
        test_latency();
        test_overflow();
        test_random();
        test_reset_in_write();
        test_drop_in_ack();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
